// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive path.
//   state_t     : receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   PRESCALE_*  : legal oversampling ratios (clocks per bit)
//   PAR_EVEN/ODD: encodings of the PAR_TYP input
//   maj3()      : 2-of-3 majority helper used by the optional vote sampler
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial line, frame configuration and received-word outputs of
// the UART receiver.
//   RX_IN      : serial line, idle high
//   Prescale   : clocks per bit (8, 16 or 32)
//   PAR_EN     : 1 = parity bit present in the frame
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   P_DATA     : last good received word
//   Data_Valid : one-cycle strobe, P_DATA updated
//   Par_err    : one-cycle strobe, parity mismatch
//   Stop_err   : one-cycle strobe, stop bit sampled low
// Modports: master = line/config driver side, slave = the receiver.
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_err;
    logic                  Stop_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_err, Stop_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_err, Stop_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit edge counter and bit-value decision for the UART receiver.
//   CLK, RST    : oversampling clock, asynchronous active-low reset
//   rx_s        : synchronized serial line
//   run         : 1 = keep counting next cycle, 0 = park the counter at 0
//   prescale    : clocks per bit for the current frame
//   sampled_bit : bit value, valid when sample_done is high
//   sample_done : decision cycle of the current bit
//   bit_done    : last edge of the current bit (edge_cnt == prescale-1)
// Build option UART_RX_MAJORITY_VOTE_EN: when defined the bit value is the
// 2-of-3 majority of samples at prescale/2-1, prescale/2 and prescale/2+1,
// and the decision moves to prescale/2+1. Otherwise a single sample at
// prescale/2 is used.
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_s,
    input  logic       run,
    input  logic [5:0] prescale,
    output logic       sampled_bit,
    output logic       sample_done,
    output logic       bit_done
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic [5:0] last_edge;

    assign half      = prescale >> 1;
    assign last_edge = prescale - 6'd1;
    assign bit_done  = (edge_cnt == last_edge);

    // The counter runs 0..prescale-1 and wraps per bit. When the FSM is
    // idle (or about to return to idle) it is held at 0, so the cycle in
    // which a start edge is detected counts as edge 0 and the next as edge 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= 6'd0;
        end else if (!run || bit_done) begin
            edge_cnt <= 6'd0;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic samp_early;
    logic samp_mid;

    // The first two votes are stored; the third is the live line value on
    // the decision cycle, so the majority is ready one edge after centre.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
        end else begin
            if (edge_cnt == half - 6'd1) begin
                samp_early <= rx_s;
            end
            if (edge_cnt == half) begin
                samp_mid <= rx_s;
            end
        end
    end

    assign sample_done = (edge_cnt == half + 6'd1);
    assign sampled_bit = maj3(samp_early, samp_mid, rx_s);
`else
    assign sample_done = (edge_cnt == half);
    assign sampled_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receive path: recovers start / DATA_WIDTH data bits (LSB first) /
// optional parity / one stop bit from an oversampled serial line and
// presents the word with a one-cycle valid strobe plus error strobes.
//   CLK  : oversampling clock
//   RST  : asynchronous active-low reset
//   bus  : uart_rx_if slave modport (RX_IN, Prescale, PAR_EN, PAR_TYP in;
//          P_DATA, Data_Valid, Par_err, Stop_err out)
// Parameters: DATA_WIDTH (data bits per frame), SYNC_STAGES (RX_IN
// synchronizer depth, at least 2).
// Build option UART_RX_MAJORITY_VOTE_EN selects 3-sample majority voting in
// uart_rx_sampler; every strobe then appears one cycle later.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t                 state_q;
    logic [5:0]             prescale_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   par_bad_q;

    logic [DATA_WIDTH-1:0]  p_data_q;
    logic                   data_valid_q;
    logic                   par_err_q;
    logic                   stop_err_q;

    logic                   run;
    logic                   sampled_bit;
    logic                   sample_done;
    logic                   bit_done;
    logic                   par_expect;

    // Synchronizer resets to the idle (high) line level so a reset release
    // never looks like a start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Counter enable: start counting on the start edge seen in IDLE, and
    // stop on any cycle where the FSM is leaving for IDLE so the counter is
    // back at 0 before the next start edge can arrive.
    always_comb begin
        run = 1'b1;
        unique case (state_q)
            IDLE:    run = ~rx_s;
            START:   run = ~(sample_done & sampled_bit);
            STOP:    run = ~sample_done;
            default: run = 1'b1;
        endcase
    end

    uart_rx_sampler u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx_s        (rx_s),
        .run         (run),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_done    (bit_done)
    );

    assign par_expect = (^shift_q) ^ (par_typ_q == PAR_ODD);

    // Receiver FSM with registered strobes. Strobes default low every cycle
    // and are raised for exactly the cycle after the deciding sample.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            prescale_q   <= PRESCALE_8;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    // Frame configuration is frozen for the whole frame.
                    if (!rx_s) begin
                        state_q    <= START;
                        prescale_q <= bus.Prescale;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        bit_cnt_q  <= '0;
                        par_bad_q  <= 1'b0;
                    end
                end

                START: begin
                    // A high start-bit sample means the edge was a glitch.
                    if (sample_done && sampled_bit) begin
                        state_q <= IDLE;
                    end else if (bit_done) begin
                        state_q <= DATA;
                    end
                end

                DATA: begin
                    // LSB arrives first, so shift in from the top.
                    if (sample_done) begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (bit_done) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (sample_done && (sampled_bit != par_expect)) begin
                        par_bad_q <= 1'b1;
                        par_err_q <= 1'b1;
                    end
                    if (bit_done) begin
                        state_q <= STOP;
                    end
                end

                STOP: begin
                    // Leave at the stop decision rather than the end of the
                    // bit, giving half a bit of margin for the next start.
                    if (sample_done) begin
                        state_q <= IDLE;
                        if (!sampled_bit) begin
                            stop_err_q <= 1'b1;
                        end else if (!par_bad_q) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_q;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.Data_Valid = data_valid_q;
    assign bus.Par_err    = par_err_q;
    assign bus.Stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are serialized onto RX_IN one
// oversampling clock at a time; for each frame the expected strobes (kind,
// P_DATA value and absolute cycle) are derived from the frame format and
// the latency rule and pushed into a scoreboard queue. A monitor pops and
// compares whenever any strobe is seen.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int SYNC = 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    localparam int K_VALID = 0;
    localparam int K_PAR   = 1;
    localparam int K_STOP  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic   CLK = 1'b0;
    logic   RST = 1'b0;
    longint cyc = 0;

    exp_t       sbq[$];
    longint     valid_log[$];
    logic [7:0] model_pdata = 8'h00;
    int         total = 0;
    int         bad   = 0;
    logic [2:0] mon_st;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) cycle=%0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input logic [7:0] data, input longint when);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = when;
        sbq.push_back(e);
    endtask

    // Serializes one frame starting at the current negedge. Expected strobe
    // times: the decision sits mid-bit, (1+8+pen) bits after the start edge,
    // plus SYNC cycles of synchronizer delay and one cycle of output register.
    task automatic applyStimulus(input logic [7:0] data, input int p, input bit pen,
                                 input bit ptyp, input bit bad_par, input bit stop_bit,
                                 input int spike_bit);
        logic [10:0] bits;
        int          nbits;
        logic        pbit;
        longint      c;
        int          l_par;
        int          l_stop;
        pbit  = (^data) ^ ptyp ^ bad_par;
        nbits = pen ? 11 : 10;
        bits  = '0;
        bits[8:1] = data;
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stop_bit;
        end else begin
            bits[9] = stop_bit;
        end
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        c      = cyc;
        l_par  = 9 * p + p / 2 + 1 + VOTE;
        l_stop = (9 + int'(pen)) * p + p / 2 + 1 + VOTE;
        if (pen && bad_par) pushExp(K_PAR, model_pdata, c + SYNC + l_par);
        if (!stop_bit) begin
            pushExp(K_STOP, model_pdata, c + SYNC + l_stop);
        end else if (!(pen && bad_par)) begin
            model_pdata = data;
            pushExp(K_VALID, data, c + SYNC + l_stop);
        end
        for (int b = 0; b < nbits; b++) begin
            for (int o = 0; o < p; o++) begin
                bus.RX_IN = (b == spike_bit && o == p / 2) ? ~bits[b] : bits[b];
                @(negedge CLK);
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sbq.size() != 0; i++) @(negedge CLK);
        checkOutput("scoreboard_drain", sbq.size(), 0);
    endtask

    task automatic checkState(input string name, input uart_rx_pkg::state_t exp_state);
        checkOutput(name, int'(dut.state_q), int'(exp_state));
    endtask

    // Monitor: any strobe consumes the oldest expectation, in time order.
    always @(negedge CLK) begin
        if (RST) begin
            mon_st = {bus.Stop_err, bus.Par_err, bus.Data_Valid};
            for (int k = 0; k < 3; k++) begin
                int   kind;
                exp_t e;
                kind = (k == 0) ? K_PAR : ((k == 1) ? K_STOP : K_VALID);
                if (mon_st[kind]) begin
                    if (sbq.size() == 0) begin
                        checkOutput("unexpected_strobe", mon_st, 0);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput("strobe_kind", kind, e.kind);
                        checkOutput("strobe_cycle", cyc, e.cyc);
                        checkOutput("strobe_p_data", bus.P_DATA, e.data);
                        if (kind == K_VALID) valid_log.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        longint c;
        int     p;
        bit     pen;
        bit     ptyp;
        bit     bpar;
        bit     stp;
        int     gap;

        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        RST          = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_p_data", bus.P_DATA, 0);
        checkOutput("reset_data_valid", bus.Data_Valid, 0);
        checkOutput("reset_par_err", bus.Par_err, 0);
        checkOutput("reset_stop_err", bus.Stop_err, 0);
        checkState("reset_state", uart_rx_pkg::IDLE);
        RST = 1'b1;
        idleCycles(8);

        $display("[TB] basic frame 0xA5, prescale 8");
        applyStimulus(8'hA5, 8, 0, 0, 0, 1, -1);
        idleCycles(8);
        drain(200);

        $display("[TB] even parity frames, prescale 16");
        applyStimulus(8'h3C, 16, 1, 0, 0, 1, -1);
        idleCycles(16);
        applyStimulus(8'h3C, 16, 1, 0, 1, 1, -1);
        idleCycles(16);
        drain(400);
        checkOutput("p_data_hold_after_par_err", bus.P_DATA, model_pdata);

        $display("[TB] stop error frame, prescale 32, odd parity");
        applyStimulus(8'h01, 32, 1, 1, 0, 0, -1);
        idleCycles(64);
        drain(800);
        checkState("idle_after_stop_err", uart_rx_pkg::IDLE);
        checkOutput("p_data_hold_after_stop_err", bus.P_DATA, model_pdata);

        $display("[TB] start glitch, prescale 16");
        bus.Prescale = 6'd16;
        c = cyc;
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        checkState("glitch_entered_start", uart_rx_pkg::START);
        bus.RX_IN = 1'b1;
        repeat (7 + VOTE) @(negedge CLK);
        checkOutput("glitch_timing_ref", cyc - c, 10 + VOTE);
        checkState("glitch_still_start", uart_rx_pkg::START);
        @(negedge CLK);
        checkState("glitch_back_idle", uart_rx_pkg::IDLE);
        idleCycles(16);

`ifdef UART_RX_MAJORITY_VOTE_EN
        $display("[TB] single-clock spike at the sample point");
        applyStimulus(8'h5A, 16, 0, 0, 0, 1, 4);
        idleCycles(16);
        drain(400);
`endif

        $display("[TB] back-to-back frames 0x55, 0xAA");
        valid_log.delete();
        applyStimulus(8'h55, 8, 0, 0, 0, 1, -1);
        applyStimulus(8'hAA, 8, 0, 0, 0, 1, -1);
        idleCycles(8);
        drain(200);
        if (valid_log.size() == 2)
            checkOutput("b2b_spacing", valid_log[1] - valid_log[0], 80);
        else
            checkOutput("b2b_valid_count", valid_log.size(), 2);

        $display("[TB] reset in the middle of a frame");
        valid_log.delete();
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        RST = 1'b0;
        model_pdata = 8'h00;
        repeat (4) begin
            @(negedge CLK);
            checkOutput("in_reset_p_data", bus.P_DATA, 0);
            checkOutput("in_reset_data_valid", bus.Data_Valid, 0);
            checkOutput("in_reset_par_err", bus.Par_err, 0);
            checkOutput("in_reset_stop_err", bus.Stop_err, 0);
        end
        RST = 1'b1;
        idleCycles(16);
        applyStimulus(8'h12, 8, 0, 0, 0, 1, -1);
        idleCycles(8);
        drain(200);
        checkOutput("after_reset_valid_count", valid_log.size(), 1);

        $display("[TB] randomized frames");
        for (int n = 0; n < 30; n++) begin
            p    = 8 << $urandom_range(0, 2);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            bpar = pen && ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            applyStimulus(8'($urandom), p, pen, ptyp, bpar, stp, -1);
            if (!stp)
                gap = p + int'($urandom_range(0, 8));
            else
                gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
            idleCycles(gap);
        end
        idleCycles(40);
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
